mem_arbiter: RTL and testbench

- Arbiter and sequencer for a single shared, variable-latency memory port. Two requesters share it: the IF-stage instruction fetch and the MEM-stage load/store.
- Serialises accesses, drives the memory handshake and returns data to each requester.
- Generates per-stage stall signals, which the hazard logic uses to freeze the PC, IF/ID and the later pipeline latches.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one variable-latency memory port between IF fetch and MEM load/store.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses whose ramAck never arrives.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifReady,
  output logic              ifStall,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWData,
  output logic [DATA_W-1:0] memRData,
  output logic              memReady,
  output logic              memStall,
  output logic              ramReq,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWData,
  input  logic [DATA_W-1:0] ramRData,
  input  logic              ramAck,
  output logic              busy,
  output logic              error
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_MEM
`ifdef ARB_TIMEOUT_EN
    , ABORT
`endif
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] starve_cnt;
  logic          if_pend, mem_pend;
  logic          grant_if, grant_mem, done;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]     TIMEOUT_LIM = WW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA  = DATA_W'(32'hDEADBEEF);
  logic [WW-1:0] wait_cnt;
  logic          timeout_hit;
`else
  assign error = 1'b0;
`endif

  // A requester in its ready cycle has just been served and must not be re-granted.
  assign if_pend  = ifReq & ~ifReady;
  assign mem_pend = (memRead | memWrite) & ~memReady;
  assign ifStall  = if_pend;
  assign memStall = mem_pend;
  assign ramReq   = (state == GRANT_IF) || (state == GRANT_MEM);
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    next_state = state;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    done       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mem_pend && (!if_pend || starve_cnt < STARVE_LIM)) begin
          next_state = GRANT_MEM;
          grant_mem  = 1'b1;
        end else if (if_pend) begin
          next_state = GRANT_IF;
          grant_if   = 1'b1;
        end
      end
      GRANT_IF, GRANT_MEM: begin
        if (ramAck) begin
          next_state = IDLE;
          done       = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LIM) begin
          next_state  = ABORT;
          timeout_hit = 1'b1;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments; reset is synchronous, seen only at the edge.
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ramWe      <= 1'b0;
      ramAddr    <= '0;
      ramWData   <= '0;
      ifData     <= '0;
      memRData   <= '0;
      ifReady    <= 1'b0;
      memReady   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      error      <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      ifReady  <= 1'b0;
      memReady <= 1'b0;

      if (grant_mem) begin
        ramAddr  <= memAddr;
        ramWData <= memWData;
        ramWe    <= memWrite;
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      end else if (state == IDLE) begin
        starve_cnt <= '0;
      end

      if (grant_if) begin
        ramAddr  <= ifAddr;
        ramWData <= '0;
        ramWe    <= 1'b0;
      end

      // ramWe still holds the granted direction, so a completed write leaves memRData alone.
      if (done) begin
        ramWe <= 1'b0;
        if (state == GRANT_IF) begin
          ifData  <= ramRData;
          ifReady <= 1'b1;
        end else begin
          memReady <= 1'b1;
          if (!ramWe) memRData <= ramRData;
        end
      end

`ifdef ARB_TIMEOUT_EN
      if (timeout_hit) begin
        ramWe <= 1'b0;
        error <= 1'b1;
        if (state == GRANT_IF) begin
          ifData  <= ABORT_DATA;
          ifReady <= 1'b1;
        end else begin
          memReady <= 1'b1;
          if (!ramWe) memRData <= ABORT_DATA;
        end
      end
      if (grant_if || grant_mem || done) wait_cnt <= '0;
      else if (ramReq) wait_cnt <= wait_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; the ARB_TIMEOUT_EN scenario runs only when that macro is defined.
module tb_mem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifReq = 1'b0;
  logic [AW-1:0] ifAddr = '0;
  logic [DW-1:0] ifData;
  logic          ifReady, ifStall;
  logic          memRead = 1'b0, memWrite = 1'b0;
  logic [AW-1:0] memAddr = '0;
  logic [DW-1:0] memWData = '0;
  logic [DW-1:0] memRData;
  logic          memReady, memStall;
  logic          ramReq, ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWData;
  logic [DW-1:0] ramRData = '0;
  logic          ramAck = 1'b0;
  logic          busy, error;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifReady(ifReady), .ifStall(ifStall),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady), .memStall(memStall),
    .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
    .ramRData(ramRData), .ramAck(ramAck), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 load/store) and the captured request.
  int            m_owner, m_streak, m_wait;
  bit            m_abort, m_we, m_if_rdy, m_mem_rdy, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_data, m_mem_data;

  bit auto_req = 0, auto_mem = 0;
  int lat_max = 3, lat_left = 0;

  function automatic void model_reset();
    m_owner = 0; m_streak = 0; m_wait = 0; m_abort = 0; m_we = 0;
    m_if_rdy = 0; m_mem_rdy = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_data = '0; m_mem_data = '0;
  endfunction

  function automatic void model_edge();
    bit n_if_rdy, n_mem_rdy, want_if, want_mem;
    n_if_rdy = 0;
    n_mem_rdy = 0;
    want_if  = ifReq && !m_if_rdy;
    want_mem = (memRead || memWrite) && !m_mem_rdy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_abort) begin
      m_abort = 0;
    end else if (m_owner != 0) begin
      if (ramAck) begin
        if (m_owner == 1) begin m_if_data = ramRData; n_if_rdy = 1; end
        else begin n_mem_rdy = 1; if (!m_we) m_mem_data = ramRData; end
        m_owner = 0;
      end else begin
        m_wait++;
`ifdef ARB_TIMEOUT_EN
        if (m_wait == TIMEOUT) begin
          if (m_owner == 1) begin m_if_data = 32'hDEADBEEF; n_if_rdy = 1; end
          else begin n_mem_rdy = 1; if (!m_we) m_mem_data = 32'hDEADBEEF; end
          m_err = 1; m_abort = 1; m_owner = 0;
        end
`endif
      end
    end else if (want_mem && (!want_if || m_streak < STARVE_MAX)) begin
      m_owner = 2; m_addr = memAddr; m_wdata = memWData; m_we = memWrite; m_wait = 0;
      m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
    end else if (want_if) begin
      m_owner = 1; m_addr = ifAddr; m_wdata = '0; m_we = 0; m_wait = 0; m_streak = 0;
    end else begin
      m_streak = 0;
    end
    m_if_rdy = n_if_rdy;
    m_mem_rdy = n_mem_rdy;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ramReq", 64'(ramReq), 64'(m_owner != 0));
    check("ramWe", 64'(ramWe), 64'(m_owner == 2 && m_we));
    check("ramAddr", 64'(ramAddr), 64'(m_addr));
    if (m_owner == 2) check("ramWData", 64'(ramWData), 64'(m_wdata));
    check("ifReady", 64'(ifReady), 64'(m_if_rdy));
    check("memReady", 64'(memReady), 64'(m_mem_rdy));
    check("ifData", 64'(ifData), 64'(m_if_data));
    check("memRData", 64'(memRData), 64'(m_mem_data));
    check("busy", 64'(busy), 64'(m_owner != 0 || m_abort));
    check("ifStall", 64'(ifStall), 64'(ifReq && !m_if_rdy));
    check("memStall", 64'(memStall), 64'(memRead || memWrite) & 64'(!m_mem_rdy));
    check("error", 64'(error), 64'(m_err));
  endtask

  // Requesters hold operands until their ready cycle; the memory acks after 0..lat_max extra cycles.
  task automatic drive_random();
    if (auto_req) begin
      if (!ifReq || ifReady) begin
        ifReq  = ($urandom_range(0, 2) != 0);
        ifAddr = $urandom;
      end
      if (!(memRead || memWrite) || memReady) begin
        case ($urandom_range(0, 3))
          0: begin memRead = 0; memWrite = 0; end
          1: begin memRead = 1; memWrite = 0; end
          2: begin memRead = 0; memWrite = 1; end
          default: begin memRead = 1; memWrite = 1; end
        endcase
        memAddr  = $urandom;
        memWData = $urandom;
      end
    end
    if (auto_mem) begin
      ramRData = $urandom;
      if (ramReq) begin
        if (lat_left == 0) begin
          ramAck   = 1;
          lat_left = $urandom_range(0, lat_max);
        end else begin
          ramAck = 0;
          lat_left--;
        end
      end else begin
        ramAck = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
      drive_random();
    end
  endtask

  initial begin
    // Reset held for two edges with a fetch already requested.
    rst_n = 0; ifReq = 1; ifAddr = 32'h40;
    @(posedge clk);
    #1;
    model_reset();
    step(2);
    check("rst_ramReq", 64'(ramReq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Fetch only: granted on the first edge after release, acked in the second ramReq cycle.
    rst_n = 1;
    step();
    check("fetch_req", 64'(ramReq), 64'd1);
    check("fetch_addr", 64'(ramAddr), 64'h40);
    check("fetch_we", 64'(ramWe), 64'd0);
    step();
    ramAck = 1; ramRData = 32'h8C010004;
    check("fetch_stall", 64'(ifStall), 64'd1);
    step();
    ramAck = 0;
    check("fetch_ready", 64'(ifReady), 64'd1);
    check("fetch_data", 64'(ifData), 64'h8C010004);
    check("fetch_stall_done", 64'(ifStall), 64'd0);
    ifReq = 0;
    step();
    check("fetch_ready_pulse", 64'(ifReady), 64'd0);

    // Collision: MEM wins, IF is granted on the memReady edge.
    ifReq = 1; ifAddr = 32'h200; memRead = 1; memAddr = 32'h100;
    step();
    check("coll_mem_addr", 64'(ramAddr), 64'h100);
    ramAck = 1; ramRData = 32'h11112222;
    step();
    ramAck = 0;
    check("coll_mem_ready", 64'(memReady), 64'd1);
    check("coll_mem_data", 64'(memRData), 64'h11112222);
    memRead = 0;
    step();
    check("coll_if_req", 64'(ramReq), 64'd1);
    check("coll_if_addr", 64'(ramAddr), 64'h200);
    ramAck = 1; ramRData = 32'h33334444;
    step();
    ramAck = 0; ifReq = 0;
    check("coll_if_data", 64'(ifData), 64'h33334444);
    step();

    // Both requesters held continuously with single-cycle acks.
    auto_mem = 1; lat_max = 0; lat_left = 0;
    memWrite = 1; memAddr = 32'h300; memWData = 32'hA5A5A5A5; ifReq = 1; ifAddr = 32'h400;
    step(16);
    memWrite = 0; ifReq = 0;
    step(4);
    auto_mem = 0; ramAck = 0;
    step();

    // Reset mid-access: the later ack must be ignored.
    memRead = 1; memAddr = 32'h500;
    step();
    check("rma_req", 64'(ramReq), 64'd1);
    rst_n = 0;
    step();
    rst_n = 1; memRead = 0; ramAck = 1; ramRData = 32'hBAD0BAD0;
    step();
    ramAck = 0;
    check("rma_ready", 64'(memReady), 64'd0);
    check("rma_data", 64'(memRData), 64'd0);
    step();

    // Randomized traffic.
    auto_req = 1; auto_mem = 1; lat_max = 3; lat_left = 0;
    step(2000);
    auto_req = 0; ifReq = 0; memRead = 0; memWrite = 0;
    step(10);
    auto_mem = 0; ramAck = 0;
    step();

`ifdef ARB_TIMEOUT_EN
    // A load that is never acked aborts after TIMEOUT cycles of ramReq.
    memRead = 1; memAddr = 32'h600;
    step();
    step(TIMEOUT);
    check("to_req", 64'(ramReq), 64'd0);
    check("to_ready", 64'(memReady), 64'd1);
    check("to_data", 64'(memRData), 64'hDEADBEEF);
    check("to_error", 64'(error), 64'd1);
    memRead = 0;
    step(3);
    check("to_error_sticky", 64'(error), 64'd1);
    rst_n = 0;
    step();
    rst_n = 1;
    check("to_error_clear", 64'(error), 64'd0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
